// File: rtl/reg_display_scan.sv
// Debug display scanner: latches one register-file (or PC) value per display frame
// and scans it as 8 hex digits onto a multiplexed, active-low 7-segment display.
module reg_display_scan #(
  parameter int DIGIT_DIV   = 50000,
  parameter int HOLD_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        auto_en,
  input  logic [4:0]  man_sel,
  input  logic        show_pc,
  input  logic [31:0] pc,
  input  logic [31:0] reg_data,
  output logic [4:0]  reg_sel,
  output logic [4:0]  cur_idx,
  output logic [7:0]  disp_an,
  output logic [7:0]  disp_seg
);

  localparam int PW = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(DIGIT_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    dig_q, dig_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [4:0]    sel_q, sel_d;
  logic [4:0]    cur_idx_q, cur_idx_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          pc_mode_q, pc_mode_d;
  logic          tick_s;
  logic          frame_s;
  logic [3:0]    nib_s;

  // Segment pattern {g,f,e,d,c,b,a}, active-low, for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0:    p = 7'h40;
      4'h1:    p = 7'h79;
      4'h2:    p = 7'h24;
      4'h3:    p = 7'h30;
      4'h4:    p = 7'h19;
      4'h5:    p = 7'h12;
      4'h6:    p = 7'h02;
      4'h7:    p = 7'h78;
      4'h8:    p = 7'h00;
      4'h9:    p = 7'h10;
      4'hA:    p = 7'h08;
      4'hB:    p = 7'h03;
      4'hC:    p = 7'h46;
      4'hD:    p = 7'h21;
      4'hE:    p = 7'h06;
      4'hF:    p = 7'h0E;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

  // Next-state: prescaler/digit scan, and frame-boundary capture and selection.
  always_comb begin
    pre_d     = pre_q;
    dig_d     = dig_q;
    hold_d    = hold_q;
    sel_d     = sel_q;
    cur_idx_d = cur_idx_q;
    shadow_d  = shadow_q;
    pc_mode_d = pc_mode_q;
    tick_s    = (pre_q == PRE_LAST);
    frame_s   = tick_s && (dig_q == 3'd7);

    if (tick_s) begin
      pre_d = '0;
      dig_d = dig_q + 3'd1;
    end else begin
      pre_d = pre_q + PW'(1);
    end

    // Capture uses the old sel, so cur_idx always names the value in shadow.
    if (frame_s) begin
      shadow_d  = show_pc ? pc : reg_data;
      cur_idx_d = sel_q;
      pc_mode_d = show_pc;
      if (auto_en) begin
        if (hold_q == HOLD_LAST) begin
          sel_d  = sel_q + 5'd1;
          hold_d = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end else begin
        sel_d  = man_sel;
        hold_d = '0;
      end
    end else begin
      sel_d = sel_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q     <= '0;
      dig_q     <= 3'd0;
      hold_q    <= '0;
      sel_q     <= 5'd0;
      cur_idx_q <= 5'd0;
      shadow_q  <= 32'd0;
      pc_mode_q <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      dig_q     <= dig_d;
      hold_q    <= hold_d;
      sel_q     <= sel_d;
      cur_idx_q <= cur_idx_d;
      shadow_q  <= shadow_d;
      pc_mode_q <= pc_mode_d;
    end
  end

  // Display decode from registered state only.
  always_comb begin
    nib_s    = shadow_q[{dig_q, 2'b00} +: 4];
    disp_an  = ~(8'b1 << dig_q);
    disp_seg = {~(pc_mode_q && (dig_q == 3'd7)), hex7(nib_s)};
  end

  assign reg_sel = sel_q;
  assign cur_idx = cur_idx_q;

endmodule

// File: tb/tb_reg_display_scan.sv
// Scoreboard bench for reg_display_scan: a cycle-count reference model predicts
// each edge's outputs into a queue; a negedge monitor pops and compares.
module tb_reg_display_scan;

  localparam int DD = 4;
  localparam int HF = 2;
  localparam int FRAME = 8 * DD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        auto_en = 1'b1;
  logic [4:0]  man_sel = 5'd0;
  logic        show_pc = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [31:0] reg_data;
  logic [4:0]  reg_sel, cur_idx;
  logic [7:0]  disp_an, disp_seg;

  logic [31:0] rf [32];
  assign reg_data = rf[reg_sel];

  reg_display_scan #(.DIGIT_DIV(DD), .HOLD_FRAMES(HF)) dut (
    .clk(clk), .rst(rst), .auto_en(auto_en), .man_sel(man_sel),
    .show_pc(show_pc), .pc(pc), .reg_data(reg_data), .reg_sel(reg_sel),
    .cur_idx(cur_idx), .disp_an(disp_an), .disp_seg(disp_seg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] sel;
    logic [4:0] cur;
    logic [7:0] an;
    logic [7:0] seg;
  } obs_t;

  obs_t expq[$];
  obs_t mon_e;
  int checks = 0;
  int errors = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model: edges counted since reset release
  int          n;
  int          frames_held;
  logic [4:0]  m_sel, m_cur;
  logic [31:0] m_shadow;
  bit          m_pcm;

  function automatic obs_t model_out();
    obs_t o;
    int d;
    logic [31:0] sh;
    d = (n / DD) % 8;
    sh = m_shadow >> (4 * d);
    o.sel = m_sel;
    o.cur = m_cur;
    o.an  = ~(8'd1 << d);
    o.seg = hex_tab[sh[3:0]] & ((m_pcm && d == 7) ? 8'h7F : 8'hFF);
    return o;
  endfunction

  task automatic model_reset();
    n = 0; frames_held = 0; m_sel = 5'd0; m_cur = 5'd0; m_shadow = 32'd0; m_pcm = 1'b0;
  endtask

  task automatic model_edge();
    n = n + 1;
    if (n % FRAME == 0) begin
      m_shadow = show_pc ? pc : rf[m_sel];
      m_cur    = m_sel;
      m_pcm    = show_pc;
      if (auto_en) begin
        frames_held = frames_held + 1;
        if (frames_held == HF) begin
          m_sel = 5'((int'(m_sel) + 1) % 32);
          frames_held = 0;
        end
      end else begin
        m_sel = man_sel;
        frames_held = 0;
      end
    end
  endtask

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s t=%0t got sel=%0d cur=%0d an=%h seg=%h expected sel=%0d cur=%0d an=%h seg=%h",
               name, $time, act.sel, act.cur, act.an, act.seg, exp.sel, exp.cur, exp.an, exp.seg);
    end
  endtask

  // One active edge: predict, enqueue, return at the following negedge.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    expq.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        mon_e = expq.pop_front();
        chk("scan", {reg_sel, cur_idx, disp_an, disp_seg}, mon_e);
      end
    end
  end

  initial begin
    obs_t rst_obs;
    bit found;
    rst_obs = {5'd0, 5'd0, 8'hFE, 8'hC0};
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
    model_reset();

    run(3);
    rst = 1'b0;
    run(31);
    run(2100);

    rf[5] = 32'hDEAD_BEEF;
    auto_en = 1'b0;
    man_sel = 5'd5;
    run(80);

    show_pc = 1'b1;
    pc = 32'h0000_3004;
    run(70);
    show_pc = 1'b0;
    run(40);

    while (n % FRAME != 10) step();
    man_sel = 5'd9;
    run(40);

    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0: auto_en = 1'($urandom_range(0, 1));
          1: man_sel = 5'($urandom_range(0, 31));
          2: show_pc = 1'($urandom_range(0, 1));
          default: pc = $urandom;
        endcase
      end
      step();
    end

    auto_en = 1'b0;
    show_pc = 1'b0;
    man_sel = 5'd7;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (m_sel == 5'd7 && ((n / DD) % 8) == 3) found = 1'b1;
    end
    checks = checks + 1;
    if (!found) begin
      errors = errors + 1;
      $display("FAIL async_setup got no sel=7/digit3 slot expected one within 300 cycles");
    end
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst", {reg_sel, cur_idx, disp_an, disp_seg}, rst_obs);
    model_reset();
    @(negedge clk);
    run(2);
    rst = 1'b0;
    run(40);

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
    #1;
    checks = checks + 1;
    if (expq.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain got %0d pending expected 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
